// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the systolic FFT datapath.
//   - default data / twiddle widths
//   - complex operand and twiddle typedefs at the default widths
//   - sat_dw      : clip a wide signed value into a DW-bit range, flag overflow
//   - round_shift : arithmetic right shift by k, optionally rounding half up
// Optional feature macro: BFLY_ROUND_EN (defined = round half up before the
// shift, undefined = plain truncation toward minus infinity).
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;

    // Working width for the shift/round/saturate path. Wide enough that the
    // rounding add can never wrap for any practical DW/TW.
    localparam int WIDE = 64;

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    // Stage-1 sum/difference carry one growth bit.
    typedef struct packed {
        logic signed [DW_DEF:0] re;
        logic signed [DW_DEF:0] im;
    } cplx_ext_t;

    typedef struct packed {
        logic signed [TW_DEF-1:0] re;
        logic signed [TW_DEF-1:0] im;
    } twid_t;

    typedef struct packed {
        logic                   ovf;
        logic signed [WIDE-1:0] val;
    } sat_t;

    // Clip x into [-2^(dw-1), 2^(dw-1)-1]; ovf is set when clipping occurred.
    function automatic sat_t sat_dw(input logic signed [WIDE-1:0] x, input int dw);
        logic signed [WIDE-1:0] hi;
        logic signed [WIDE-1:0] lo;
        sat_t r;
        hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (dw - 1));
        r.ovf = 1'b0;
        r.val = x;
        if (x > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (x < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

    // Arithmetic right shift by k. With rounding enabled, 2^(k-1) is added
    // first at full width so the add itself cannot overflow.
    function automatic logic signed [WIDE-1:0] round_shift(input logic signed [WIDE-1:0] x,
                                                          input int k);
        logic signed [WIDE-1:0] t;
        t = x;
`ifdef BFLY_ROUND_EN
        if (k >= 1) begin
            t = x + (64'sd1 <<< (k - 1));
        end
`endif
        return t >>> k;
    endfunction

endpackage

// File: rtl/bfly_r2_pipe_cmul.sv
// -----------------------------------------------------------------------------
// bfly_cmul
// Registered exact complex multiplier (stage 2 of the butterfly).
//   p = d * w, pr = dr*wr - di*wi, pi = dr*wi + di*wr, DW+TW+2 bits, no loss.
// Kept in its own module so the multiplier mapping can be swapped per target.
// Ports:
//   clk, reset (sync, active-low)
//   en      : load new product; when low the registered product holds
//   dr, di  : DW+1-bit signed difference operand
//   wr, wi  : TW-bit signed twiddle
//   pr, pi  : DW+TW+2-bit signed registered products
// -----------------------------------------------------------------------------
module bfly_cmul
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [DW:0]        dr,
    input  logic [DW:0]        di,
    input  logic [TW-1:0]      wr,
    input  logic [TW-1:0]      wi,
    output logic [DW+TW+1:0]   pr,
    output logic [DW+TW+1:0]   pi
);

    localparam int PW = DW + TW + 2;

    logic signed [PW-1:0] pr_d, pr_q;
    logic signed [PW-1:0] pi_d, pi_q;

    always_comb begin
        pr_d = pr_q;
        pi_d = pi_q;
        if (en) begin
            // Operands are sign-extended to the full product width first so
            // the multiply and the add/sub are both exact.
            pr_d = PW'($signed(dr)) * PW'($signed(wr)) - PW'($signed(di)) * PW'($signed(wi));
            pi_d = PW'($signed(dr)) * PW'($signed(wi)) + PW'($signed(di)) * PW'($signed(wr));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pr_q <= '0;
            pi_q <= '0;
        end else begin
            pr_q <= pr_d;
            pi_q <= pi_d;
        end
    end

    assign pr = pr_q;
    assign pi = pi_q;

endmodule

// File: rtl/bfly_r2_pipe.sv
// -----------------------------------------------------------------------------
// bfly_r2_pipe
// Three-stage pipelined radix-2 DIF butterfly:
//   yi = xi + xj,  yj = (xi - xj) * w    (complex, signed)
// with optional per-beat divide-by-2, saturation to DW bits and a sticky
// overflow flag. Valid/ready handshake with whole-pipeline stall.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid / in_ready     : input handshake (in_ready = advance enable)
//   xi_*, xj_*  [DW]        : operand pair
//   w_*         [TW]        : twiddle, Q1.(TW-1)
//   scale                   : 1 = halve both outputs of this beat
//   out_valid / out_ready   : output handshake
//   yi_*, yj_*  [DW]        : results
//   ovf / ovf_clr           : sticky saturation flag and its clear
// Optional feature macro: BFLY_ROUND_EN (round half up instead of truncate).
// -----------------------------------------------------------------------------
module bfly_r2_pipe
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] xi_real,
    input  logic [DW-1:0] xi_imag,
    input  logic [DW-1:0] xj_real,
    input  logic [DW-1:0] xj_imag,
    input  logic [TW-1:0] w_real,
    input  logic [TW-1:0] w_imag,
    input  logic          scale,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] yi_real,
    output logic [DW-1:0] yi_imag,
    output logic [DW-1:0] yj_real,
    output logic [DW-1:0] yj_imag,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int SW = DW + 1;
    localparam int PW = DW + TW + 2;

    // ---------------- handshake ----------------
    logic out_valid_d, out_valid_q;
    logic adv;

    // The whole pipe moves when the output register is empty or being drained.
    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    // ---------------- stage 1: sum / difference ----------------
    logic                 v1_d, v1_q;
    logic signed [SW-1:0] sum_re_d, sum_re_q, sum_im_d, sum_im_q;
    logic signed [SW-1:0] dif_re_d, dif_re_q, dif_im_d, dif_im_q;
    logic        [TW-1:0] w_re_d, w_re_q, w_im_d, w_im_q;
    logic                 sc1_d, sc1_q;

    always_comb begin
        v1_d     = v1_q;
        sum_re_d = sum_re_q;
        sum_im_d = sum_im_q;
        dif_re_d = dif_re_q;
        dif_im_d = dif_im_q;
        w_re_d   = w_re_q;
        w_im_d   = w_im_q;
        sc1_d    = sc1_q;
        if (adv) begin
            v1_d = in_valid;
            // Data registers only load on a real beat; bubbles leave them alone.
            if (in_valid) begin
                sum_re_d = SW'($signed(xi_real)) + SW'($signed(xj_real));
                sum_im_d = SW'($signed(xi_imag)) + SW'($signed(xj_imag));
                dif_re_d = SW'($signed(xi_real)) - SW'($signed(xj_real));
                dif_im_d = SW'($signed(xi_imag)) - SW'($signed(xj_imag));
                w_re_d   = w_real;
                w_im_d   = w_imag;
                sc1_d    = scale;
            end
        end
    end

    // ---------------- stage 2: complex multiply, sum delayed ----------------
    logic                 v2_d, v2_q;
    logic signed [SW-1:0] sum2_re_d, sum2_re_q, sum2_im_d, sum2_im_q;
    logic                 sc2_d, sc2_q;
    logic        [PW-1:0] prod_re, prod_im;
    logic                 cmul_en;

    assign cmul_en = adv & v1_q;

    bfly_cmul #(
        .DW (DW),
        .TW (TW)
    ) u_cmul (
        .clk   (clk),
        .reset (reset),
        .en    (cmul_en),
        .dr    (dif_re_q),
        .di    (dif_im_q),
        .wr    (w_re_q),
        .wi    (w_im_q),
        .pr    (prod_re),
        .pi    (prod_im)
    );

    always_comb begin
        v2_d      = v2_q;
        sum2_re_d = sum2_re_q;
        sum2_im_d = sum2_im_q;
        sc2_d     = sc2_q;
        if (adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                sum2_re_d = sum_re_q;
                sum2_im_d = sum_im_q;
                sc2_d     = sc1_q;
            end
        end
    end

    // ---------------- stage 3: shift, round, saturate ----------------
    logic [DW-1:0] yi_re_d, yi_re_q, yi_im_d, yi_im_q;
    logic [DW-1:0] yj_re_d, yj_re_q, yj_im_d, yj_im_q;
    logic          ovf_d, ovf_q;
    sat_t          s_yir, s_yii, s_yjr, s_yji;
    logic          sat_any;
    int            k_sum, k_prod;

    always_comb begin
        // Twiddle is Q1.(TW-1): dropping TW-1 fraction bits restores data scale.
        k_sum   = int'(sc2_q);
        k_prod  = (TW - 1) + int'(sc2_q);
        s_yir   = sat_dw(round_shift(WIDE'(sum2_re_q), k_sum), DW);
        s_yii   = sat_dw(round_shift(WIDE'(sum2_im_q), k_sum), DW);
        s_yjr   = sat_dw(round_shift(WIDE'($signed(prod_re)), k_prod), DW);
        s_yji   = sat_dw(round_shift(WIDE'($signed(prod_im)), k_prod), DW);
        sat_any = s_yir.ovf | s_yii.ovf | s_yjr.ovf | s_yji.ovf;

        out_valid_d = out_valid_q;
        yi_re_d     = yi_re_q;
        yi_im_d     = yi_im_q;
        yj_re_d     = yj_re_q;
        yj_im_d     = yj_im_q;
        if (adv) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                yi_re_d = s_yir.val[DW-1:0];
                yi_im_d = s_yii.val[DW-1:0];
                yj_re_d = s_yjr.val[DW-1:0];
                yj_im_d = s_yji.val[DW-1:0];
            end
        end

        // Clear first so that a simultaneous saturation wins.
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (adv && v2_q && sat_any) begin
            ovf_d = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            sum_re_q    <= '0;
            sum_im_q    <= '0;
            dif_re_q    <= '0;
            dif_im_q    <= '0;
            w_re_q      <= '0;
            w_im_q      <= '0;
            sc1_q       <= 1'b0;
            v2_q        <= 1'b0;
            sum2_re_q   <= '0;
            sum2_im_q   <= '0;
            sc2_q       <= 1'b0;
            out_valid_q <= 1'b0;
            yi_re_q     <= '0;
            yi_im_q     <= '0;
            yj_re_q     <= '0;
            yj_im_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            sum_re_q    <= sum_re_d;
            sum_im_q    <= sum_im_d;
            dif_re_q    <= dif_re_d;
            dif_im_q    <= dif_im_d;
            w_re_q      <= w_re_d;
            w_im_q      <= w_im_d;
            sc1_q       <= sc1_d;
            v2_q        <= v2_d;
            sum2_re_q   <= sum2_re_d;
            sum2_im_q   <= sum2_im_d;
            sc2_q       <= sc2_d;
            out_valid_q <= out_valid_d;
            yi_re_q     <= yi_re_d;
            yi_im_q     <= yi_im_d;
            yj_re_q     <= yj_re_d;
            yj_im_q     <= yj_im_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign yi_real   = yi_re_q;
    assign yi_imag   = yi_im_q;
    assign yj_real   = yj_re_q;
    assign yj_imag   = yj_im_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/bfly_r2_pipe.md
# bfly_r2_pipe

Pipelined, parametrised radix-2 decimation-in-frequency butterfly for the systolic FFT datapath, superseding the combinational 16-bit butterfly. Computes yi = (xi + xj) and yj = (xi − xj)·w on complex signed operands over three register stages. Adds a valid/ready handshake with full-pipeline stall, a per-sample scale-by-½ option, saturation, and a sticky overflow flag. One instance per FFT stage column; the twiddle arrives with the operands from the twiddle ROM.

## Interface
- DW, 16: data width, signed two's complement, per real/imag component
- TW, 16: twiddle width, signed Q1.(TW−1), so −2^(TW−1) encodes exactly −1.0
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- xi_real, xi_imag, xj_real, xj_imag  in  DW each  operand pair
- w_real, w_imag  in  TW each  twiddle
- scale  in  1  1 = divide both outputs by 2 (travels with its beat)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- yi_real, yi_imag, yj_real, yj_imag  out  DW each  results
- ovf  out  1  sticky: any saturation since last clear
- ovf_clr  in  1  clears ovf

## Operation
- S1: sum = xi + xj, diff = xi − xj, per component, DW+1 bits, exact; register sum, diff, w, scale.
- S2: complex multiply of diff by w: pr = dr·wr − di·wi, pi = dr·wi + di·wr, DW+TW+2 bits, exact; sum delayed alongside.
- S3: shift sum by s = scale and products by (TW−1)+scale, arithmetic right shift; round per Configuration; saturate each to [−2^(DW−1), 2^(DW−1)−1]; register outputs.
- Any component saturating on an accepted S3 beat sets ovf the following cycle.
- ovf_clr and a saturation in the same cycle: set wins (ovf = 1).
- Bubbles (invalid stages) carry no data; their contents must not touch ovf.

## Timing
- Reset (reset = 0 at a clk edge): all stage valids 0, out_valid 0, all y outputs 0, ovf 0. Applies mid-operation; in-flight beats are discarded and no beat is emitted afterwards.
- Advance enable: adv = out_ready | ~out_valid. in_ready = adv (combinational from out_ready and out_valid only; no path from in_valid).
- When adv = 1 every stage shifts one place; when 0 all stage registers, including data, hold.
- Transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
- Latency: an input accepted in cycle n appears with out_valid in cycle n+3 with no stalls; each stall cycle adds one.
- Throughput: one beat per cycle sustained with out_ready held high.
- Outputs stable while out_valid & ~out_ready.

## Configuration
- BFLY_ROUND_EN defined: round half up, i.e. add 2^(k−1) before the k-bit shift (k ≥ 1), then saturate; the rounding add is saturation-safe (done at full width).
- BFLY_ROUND_EN undefined: plain truncation toward −∞ (arithmetic shift only).
- Both builds have identical latency and handshake.

## Structure
- Package fft_pkg: default DW/TW constants, complex data and twiddle struct typedefs parametrised by width, function sat_dw (wide signed to DW with overflow bit), and the round/shift function.
- One sub-module: bfly_cmul (S2 complex multiplier, registered, hold-enable input), so multiplier mapping can be swapped per target.

## Test plan
- DW=TW=16, scale=0, xi=(1000,0), xj=(200,0), w=(16384,0) → 3 cycles later yi=(1200,0), yj=(400,0), ovf=0.
- Same beat with scale=1 → yi=(600,0), yj=(200,0).
- xi=(100,0), xj=(0,0), w=(0,−32768), scale=0 → yj=(0,−100), yi=(100,0).
- scale=1, xi=(−1,0), xj=(−2,0): sum −3 → yi_real=−1 with BFLY_ROUND_EN, −2 without.
- xi=(32767,0), xj=(32767,0), scale=0 → yi_real=32767, ovf=1 next cycle; ovf stays 1 until ovf_clr pulse, then 0; clear in same cycle as new saturation keeps 1.
- Stream 6 beats, out_ready=0 from cycle 4 for 3 cycles → in_ready=0 while out_valid held, outputs unchanged, all 6 beats delivered in order with no loss or duplication; assert reset mid-stream → out_valid=0, outputs 0 next cycle, no stale beat after release.
